// File: rtl/button_conditioner.sv
// Pushbutton front end for the up/down counter: sync, debounce,
// hold-to-repeat and collision-dropping strobe arbitration.

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic count_up,
  output logic count_down,
  output logic up_held,
  output logic down_held
);

  localparam int MAX_A =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
    DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_V =
    (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] DEB_V = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DLY_V = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_V = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE_V = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  logic [1:0] btn_n;
  logic [1:0] req;
  logic [1:0] held;

  // bit 0 is the up channel, bit 1 the down channel
  assign btn_n = {btn_down_n, btn_up_n};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic          sync1_q;
    logic          s_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] tmr_q;
    logic [CW-1:0] tmr_inc;
    logic [CW-1:0] tmr_d;
    logic          first_q;
    logic          first_d;
    logic          rep_hit;
    logic          req_q;
    logic          held_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b1;
        s_q     <= 1'b1;
      end else begin
        sync1_q <= btn_n[g];
        s_q     <= sync1_q;
      end
    end

    always_comb begin
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
      rep_hit = (tmr_inc == (first_q ? DLY_V : PER_V));
      tmr_d   = rep_hit ? '0 : tmr_inc;
      first_d = first_q & ~rep_hit;
    end

    // Repeat timer only advances on cycles that end in HELD, so
    // time spent in DEB_RELEASE stretches the repeat spacing.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tmr_q   <= '0;
        first_q <= 1'b1;
        req_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        req_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (!s_q) begin
              state_q <= DEB_PRESS;
              cnt_q   <= ONE_V;
            end
          end
          DEB_PRESS: begin
            if (s_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_V) begin
              state_q <= HELD;
              cnt_q   <= '0;
              tmr_q   <= '0;
              first_q <= 1'b1;
              req_q   <= 1'b1;
              held_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          HELD: begin
            if (s_q) begin
              state_q <= DEB_RELEASE;
              cnt_q   <= ONE_V;
            end else if (REPEAT_EN != 0) begin
              tmr_q   <= tmr_d;
              first_q <= first_d;
              req_q   <= rep_hit;
            end
          end
          DEB_RELEASE: begin
            if (!s_q) begin
              state_q <= HELD;
              cnt_q   <= '0;
              if (REPEAT_EN != 0) begin
                tmr_q   <= tmr_d;
                first_q <= first_d;
                req_q   <= rep_hit;
              end
            end else if (cnt_q == DEB_V) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              held_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        endcase
      end
    end

    assign req[g]  = req_q;
    assign held[g] = held_q;
  end

  logic count_up_q;
  logic count_up_d;
  logic count_down_q;
  logic count_down_d;

  // Coincident requests are both dropped so the counter never
  // sees up and down together.
  always_comb begin
    count_up_d   = 1'b1;
    count_down_d = 1'b1;
    unique case (req)
      2'b01:   count_up_d   = 1'b0;
      2'b10:   count_down_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_up_q   <= 1'b1;
      count_down_q <= 1'b1;
    end else begin
      count_up_q   <= count_up_d;
      count_down_q <= count_down_d;
    end
  end

  assign count_up   = count_up_q;
  assign count_down = count_down_q;
  assign up_held    = held[0];
  assign down_held  = held[1];

endmodule
